// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (inhibit, request-to-send, 8N+odd parity, ACK check, timeout)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);
  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [3:0] {IDLE, INHIBIT, RTS, SHIFT, STOP, ACK, WAIT_REL, DONE, ERROR} state_e;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [8:0]             frame_q, frame_d;
  logic [SYNC_STAGES-1:0] csync_q, dsync_q;
  logic                   clk_prev_q;
  logic                   tx_ready_q, busy_q, done_q, error_q, clk_oe_q, data_oe_q, data_oe_d;
  logic                   clk_s, data_s, fe, timeout;
  assign clk_s      = csync_q[SYNC_STAGES-1];
  assign data_s     = dsync_q[SYNC_STAGES-1];
  assign fe         = clk_prev_q & ~clk_s;
  assign timeout    = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign tx_ready_o    = tx_ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    case (state_q)
      IDLE: if (tx_valid_i && tx_ready_q) begin
        state_d = INHIBIT;
        frame_d = {~^tx_data_i, tx_data_i};
        cnt_d   = '0;
      end
      INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
        state_d   = RTS;
        data_oe_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      RTS: begin
        state_d = SHIFT;
        bit_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: if (fe) begin
        data_oe_d = ~frame_q[bit_q];
        bit_d     = bit_q + 4'd1;
        state_d   = (bit_q == 4'd8) ? STOP : SHIFT;
      end
      STOP: if (fe) begin
        data_oe_d = 1'b0;
        state_d   = ACK;
      end
      ACK: if (fe) state_d = data_s ? ERROR : WAIT_REL;
      WAIT_REL: if (clk_s && data_s) state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Device-clocked states share one watchdog; a legitimate transition this cycle wins over it.
    if (state_q inside {SHIFT, STOP, ACK, WAIT_REL}) begin
      cnt_d = fe ? '0 : cnt_q + CW'(1);
      if (!fe && timeout && state_d == state_q) state_d = ERROR;
    end
    if (state_d inside {IDLE, DONE, ERROR}) data_oe_d = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      csync_q    <= '1;
      dsync_q    <= '1;
      clk_prev_q <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      csync_q    <= {csync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dsync_q    <= {dsync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q <= clk_s;
      tx_ready_q <= state_d == IDLE;
      busy_q     <= state_d inside {INHIBIT, RTS, SHIFT, STOP, ACK, WAIT_REL};
      done_q     <= state_d == DONE;
      error_q    <= state_d == ERROR;
      clk_oe_q   <= state_d inside {INHIBIT, RTS};
      data_oe_q  <= data_oe_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model on open-drain lines, table-driven frames plus reset/held-valid sequences
module tb_ps2_host_tx;
  localparam int INH = 50, TMO = 2000, HALF = 20;
  logic clk = 0, rst_n = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, busy, done, error, clk_oe, data_oe;
  logic dev_clk = 1, dev_data = 1;
  logic clk_line, data_line;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
  assign clk_line  = ~clk_oe & dev_clk;
  assign data_line = ~data_oe & dev_data;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .busy_o(busy), .done_o(done), .error_o(error),
    .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_oe_o(clk_oe), .ps2_data_oe_o(data_oe));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done && error) both_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Line order as the device sees it: start, d[0]..d[7], odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    return {1'b1, 1'(($countones(d) % 2) == 0), d, 1'b0};
  endfunction
  task automatic start(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_data = d;
    tx_valid = 1;
    @(posedge clk);
    #1 tx_valid = 0;
  endtask
  task automatic device(input bit nack, input int nclk, output logic [10:0] got,
                        output int inh, output int rts, output int fall_cyc);
    int n = 0;
    got = '1;
    inh = 0;
    rts = 0;
    fall_cyc = 0;
    @(negedge clk);
    while (!(data_oe && !clk_oe) && n < 2000) begin
      if (clk_oe && !data_oe) inh++;
      if (clk_oe && data_oe) rts++;
      @(negedge clk);
      n++;
    end
    chk("rts_seen", int'(n < 2000), 1);
    got[0] = data_line;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1;
      if (k <= 10) got[k] = data_line;
      if (k == 10) dev_data = nack;
      if (k == 11) dev_data = 1;
      repeat (HALF) @(negedge clk);
    end
  endtask
  task automatic wait_result(input int bd, input int be, output int expired);
    int n = 0;
    while (done_cnt + err_cnt <= bd + be && n < 6000) begin
      @(negedge clk);
      n++;
    end
    expired = int'(n >= 6000);
    repeat (5) @(negedge clk);
  endtask
  typedef struct {
    logic [7:0] d;
    bit         nack;
    int         nclk;
  } vec_t;
  vec_t v[12];
  initial begin
    logic [10:0] got, mask;
    int inh, rts, fc, bd, be, exp_ok, expired, n;
    v[0] = '{8'hED, 0, 11};
    v[1] = '{8'h00, 0, 11};
    v[2] = '{8'hFF, 0, 11};
    v[3] = '{8'h01, 0, 11};
    v[4] = '{8'h55, 1, 11};
    v[5] = '{8'h3C, 0, 4};
    for (int i = 6; i < 12; i++) v[i] = '{8'($urandom), ($urandom_range(0, 3) == 0), 11};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_ready, busy, done, error, clk_oe, data_oe}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", tx_ready, 1);
    for (int i = 0; i < 12; i++) begin
      bd = done_cnt;
      be = err_cnt;
      exp_ok = int'(!v[i].nack && v[i].nclk == 11);
      start(v[i].d);
      device(v[i].nack, v[i].nclk, got, inh, rts, fc);
      wait_result(bd, be, expired);
      chk("result_in_time", expired, 0);
      chk("inhibit_len", inh, INH);
      chk("rts_len", rts, 1);
      mask = (v[i].nclk >= 10) ? 11'h7ff : 11'((1 << (v[i].nclk + 1)) - 1);
      chk("frame_bits", int'(got & mask), int'(model_frame(v[i].d) & mask));
      chk("done_pulses", done_cnt - bd, exp_ok);
      chk("error_pulses", err_cnt - be, 1 - exp_ok);
      if (v[i].nclk < 11) chk("timeout_latency", int'(err_cyc - fc >= TMO && err_cyc - fc <= TMO + 6), 1);
      chk("idle_after", {tx_ready, busy, clk_oe, data_oe}, 4'b1000);
    end
    // tx_valid held through a transfer with a changed byte: only the latched byte goes out
    bd = done_cnt;
    be = err_cnt;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1;
    @(posedge clk);
    #1 tx_data = 8'h5A;
    device(0, 11, got, inh, rts, fc);
    wait_result(bd, be, expired);
    chk("held_first_frame", int'(got), int'(model_frame(8'hA5)));
    chk("held_first_done", done_cnt - bd, 1);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 0;
    bd = done_cnt;
    device(0, 11, got, inh, rts, fc);
    wait_result(bd, be, expired);
    chk("held_second_frame", int'(got), int'(model_frame(8'h5A)));
    chk("held_second_done", done_cnt - bd, 1);
    chk("held_no_error", err_cnt - be, 0);
    // reset in the middle of SHIFT
    bd = done_cnt;
    be = err_cnt;
    start(8'h00);
    device(0, 3, got, inh, rts, fc);
    @(negedge clk);
    chk("data_oe_before_rst", data_oe, 1);
    rst_n = 0;
    #1;
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("ready_after_midreset", tx_ready, 1);
    repeat (30) @(negedge clk);
    chk("midreset_no_done", done_cnt - bd, 0);
    chk("midreset_no_error", err_cnt - be, 0);
    chk("done_error_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
